// File: rtl/myfft_axil_regs.sv
// rtl/myfft_axil_regs.sv - AXI4-Lite slave with four 32-bit control registers and an fft_start pulse.
// Optional MYFFT_IRQ_EN adds a sticky fft_done flag gated by reg1[0] onto irq.
module myfft_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg3,
  output logic                            fft_start,
  input  logic                            fft_done,
  output logic                            irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  logic          awready_q, awready_d;
  logic          bvalid_q, bvalid_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          start_q, start_d;
  logic [DW-1:0] reg_q [4];
  logic [DW-1:0] reg_d [4];
  logic [1:0]    wr_idx;
  logic [1:0]    rd_idx;
  logic          commit;
  logic          reg0_commit;

  assign wr_idx      = S_AXI_AWADDR[3:2];
  assign rd_idx      = S_AXI_ARADDR[3:2];
  // The single-cycle AWREADY/WREADY pulse marks the edge at which the write lands.
  assign commit      = awready_q;
  assign reg0_commit = commit && (wr_idx == 2'd0);

  always_comb begin
    awready_d = S_AXI_AWVALID && S_AXI_WVALID && !awready_q && !bvalid_q;
    bvalid_d  = bvalid_q;
    if (commit) begin
      bvalid_d = 1'b1;
    end else if (S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      reg_d[i] = reg_q[i];
    end
    if (commit) begin
      for (int b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b]) begin
          reg_d[wr_idx][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
        end
      end
    end
    start_d = reg0_commit && S_AXI_WSTRB[0] && S_AXI_WDATA[0];

    arready_d = S_AXI_ARVALID && !arready_q && !rvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    // Loaded from reg_q, so a same-edge write to the same register is not yet visible.
    if (arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = reg_q[rd_idx];
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      start_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        reg_q[i] <= '0;
      end
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      start_q   <= start_d;
      for (int i = 0; i < 4; i++) begin
        reg_q[i] <= reg_d[i];
      end
    end
  end

`ifdef MYFFT_IRQ_EN
  logic flag_q, flag_d;
  logic irq_q, irq_d;

  always_comb begin
    // fft_done takes priority over the reg0-write clear.
    flag_d = fft_done || (flag_q && !reg0_commit);
    irq_d  = flag_q && reg_q[1][0];
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      flag_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
  wire unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  assign irq = 1'b0;
  wire unused_ok = &{1'b0, fft_done, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`endif

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign fft_start     = start_q;
  assign cfg_reg0      = reg_q[0];
  assign cfg_reg1      = reg_q[1];
  assign cfg_reg2      = reg_q[2];
  assign cfg_reg3      = reg_q[3];

endmodule

// File: doc/myfft_axil_regs.md
# myfft_axil_regs

AXI4-Lite slave register file for the myFFT IP, the responder end of the S00_AXI port that the AXI VIP master drives. It decodes four 32-bit control registers at offsets 0x0 through 0xC and handles AW/W/B and AR/R handshakes. It exports register contents and a one-cycle `fft_start` pulse to the FFT datapath.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.

Ports:
- S_AXI_ACLK  in  1  the single clock; all logic is rising-edge.
- S_AXI_ARESETN  in  1  synchronous reset, active-low.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte-lane enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  write response, always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response, always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- cfg_reg0..cfg_reg3  out  32 each  current register contents.
- fft_start  out  1  one-cycle pulse.
- fft_done  in  1  completion pulse from the datapath; used only with MYFFT_IRQ_EN.
- irq  out  1  interrupt; tied to 0 without MYFFT_IRQ_EN.

## Operation
- Registers reg0–reg3 are plain read/write storage. A read returns exactly the last value written, with strobe masking applied.
- Write commit:
  - When AWVALID and WVALID are both high, and neither AWREADY nor BVALID is high, AWREADY and WREADY assert together for exactly one cycle.
  - At that cycle's clock edge, register AWADDR[3:2] is updated. Byte lane b is written only when WSTRB[b]=1; the other lanes keep their old value.
- fft_start: asserts in the cycle after a commit to reg0 where WSTRB[0]=1 and WDATA[0]=1. It lasts one cycle and does not auto-clear reg0.
- Write response: BVALID sets in the cycle after the commit and holds until BREADY is sampled high. No new write is accepted while BVALID=1.
- Read accept:
  - When ARVALID=1, ARREADY=0 and RVALID=0, ARREADY asserts for one cycle.
  - At that edge, RDATA is loaded from register ARADDR[3:2] and RVALID sets.
  - RVALID and RDATA hold until RREADY is sampled high.
- Read and write channels are independent and may complete in the same cycle.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- Reset mid-transaction: all READY/VALID outputs drop and the pending transaction is discarded without a response. The master must reissue it.

## Timing
- Reset values: all registers and cfg_reg* are 0. AWREADY, WREADY, BVALID, ARREADY, RVALID, fft_start and irq are 0. RDATA, BRESP and RRESP are 0.
- Write latency, with AWVALID and WVALID arriving together in cycle N:
  - AWREADY/WREADY high in N+1.
  - Register updated at the end of N+1.
  - BVALID and fft_start high in N+2.
- Write with AWVALID and WVALID skewed: acceptance waits until both are high. The first-arriving valid is held by the master.
- Read latency, with ARVALID in cycle N: ARREADY high in N+1, RVALID high in N+2.
- Back-to-back throughput: one write per 3 cycles and one read per 3 cycles when BREADY and RREADY are held high.

## Configuration
- MYFFT_IRQ_EN defined:
  - A sticky flag sets on any cycle with fft_done=1.
  - The flag clears in the cycle after any write commit to reg0. If fft_done and a reg0 commit coincide, set wins.
  - irq = flag & reg1[0], registered, so irq follows with one cycle of delay.
- MYFFT_IRQ_EN undefined: the flag logic is absent, irq is constant 0 and fft_done is unused.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read all four back → RDATA is 0x1, 0x2, 0x3, 0x4, every BRESP and RRESP is 2'b00, and fft_start pulses once.
- Write 0xAABBCCDD to 0x8, then 0x11223344 with WSTRB=4'b0101 → a read of 0x8 returns 0xAA22CC44.
- AWVALID 3 cycles before WVALID, with BREADY held low for 5 cycles → a single AWREADY/WREADY pulse, BVALID held for all 5 cycles, and a second write is not accepted until BREADY is high.
- Read of 0x4 concurrent with a write of 0x5 to 0x4 (reg1 = 0x2 beforehand) → RDATA is 0x2, and a subsequent read returns 0x5.
- Deassert S_AXI_ARESETN for 1 cycle while RVALID=1 → RVALID is 0 and cfg_reg0..3 are 0 on the next cycle.
- With MYFFT_IRQ_EN: write reg1=0x1, then pulse fft_done → irq rises 2 cycles after the pulse, and a write of 0x0 to reg0 clears it.
